// File: rtl/jtcps_mmr_shadow.sv
`default_nettype none
// ============================================================================
// Module   : jtcps_mmr_shadow
// Purpose  : CPS-A video registers in shadow/active pairs with a VBLANK
//            commit, byte-lane writes, DMA/palette strobes, and the CPS-B
//            configurable ID/multiplier window with a shift-add multiplier.
//            An access with dsn == 2'b11 is a read; any lane low is a write.
// Options  : JTCPS_MMR_READBACK_EN - CPS-A reads return the shadow value.
// Revision : 1.0 - initial release
// ============================================================================
module jtcps_mmr_shadow #(
  parameter int          NREGS    = 18,
  parameter int          MULW     = 16,
  parameter logic [31:0] IMM_MASK = 32'h0000_0021,
  parameter int          CFGSIZE  = 8
)(
  input  logic                 clk,
  input  logic                 reg_rst,
  input  logic                 pxl_cen,
  input  logic                 vblank,
  input  logic                 ppu1_cs,
  input  logic                 ppu2_cs,
  input  logic [4:0]           addr,
  input  logic [1:0]           dsn,
  input  logic [15:0]          cpu_dout,
  output logic [15:0]          mmr_dout,
  input  logic                 cfg_we,
  input  logic [7:0]           cfg_data,
  output logic [16*NREGS-1:0]  regs_act,
  output logic                 commit,
  output logic                 obj_dma_ok,
  output logic                 pal_copy,
  output logic                 mul_busy
);

  localparam logic [5:0]      c_nregs = 6'(NREGS);
  localparam int              c_cw    = (MULW > 1) ? $clog2(MULW) : 1;
  localparam logic [c_cw-1:0] c_last  = MULW[c_cw-1:0] - 1'b1;

  logic [8*CFGSIZE-1:0] r_cfg;
  logic [15:0]          r_shadow [NREGS];
  logic [15:0]          r_active [NREGS];
  logic                 r_dirty, r_vb_d, r_commit;
  logic                 r_arm_dma, r_arm_pal, r_dma, r_pal;
  logic [MULW-1:0]      r_mult1, r_mult2, r_mplier;
  logic [2*MULW-1:0]    r_rslt, r_acc, r_mcand;
  logic [c_cw-1:0]      r_cnt;
  logic                 r_busy;
  logic [15:0]          r_dout;

  // Config byte fields: addresses are stored pre-shifted (word addr << 1)
  logic [4:0] w_id_addr, w_m1_addr, w_m2_addr, w_r0_addr, w_r1_addr;
  logic [7:0] w_id_val;
  assign w_id_addr = r_cfg[5:1];
  assign w_id_val  = r_cfg[15:8];
  assign w_m1_addr = r_cfg[21:17];
  assign w_m2_addr = r_cfg[29:25];
  assign w_r0_addr = r_cfg[37:33];
  assign w_r1_addr = r_cfg[45:41];

  logic w_cfg_unused, w_rsvd_unused;
  assign w_cfg_unused = ^{r_cfg[0], r_cfg[7:6], r_cfg[16], r_cfg[23:22], r_cfg[24],
                          r_cfg[31:30], r_cfg[32], r_cfg[39:38], r_cfg[40], r_cfg[47:46],
                          w_rsvd_unused};
  generate
    if (CFGSIZE > 6) begin : g_rsvd
      assign w_rsvd_unused = ^r_cfg[8*CFGSIZE-1:48];
    end else begin : g_no_rsvd
      assign w_rsvd_unused = 1'b0;
    end
  endgenerate

  // CPS-A write decode and byte-lane merge
  logic        w_a_hit, w_a_wr, w_dly_wr, w_vb_rise, w_commit;
  logic [15:0] w_old, w_merged;
  assign w_a_hit   = ppu1_cs && ({1'b0, addr} < c_nregs);
  assign w_a_wr    = w_a_hit && (dsn != 2'b11);
  assign w_dly_wr  = w_a_wr && !IMM_MASK[addr];
  assign w_old     = r_shadow[addr];
  assign w_merged  = {dsn[1] ? w_old[15:8] : cpu_dout[15:8],
                      dsn[0] ? w_old[7:0]  : cpu_dout[7:0]};
  assign w_vb_rise = vblank && !r_vb_d;
  assign w_commit  = w_vb_rise && r_dirty;

  // Config download shifts toward byte 0; deliberately survives reset
  always_ff @(posedge clk) begin
    if (cfg_we) r_cfg <= {cfg_data, r_cfg[8*CFGSIZE-1:8]};
  end

  // Shadow/active register file; commit copies pre-write shadow values
  always_ff @(posedge clk or posedge reg_rst) begin
    if (reg_rst) begin
      for (int n = 0; n < NREGS; n++) begin
        r_shadow[n] <= '0;
        r_active[n] <= '0;
      end
      r_dirty  <= 1'b0;
      r_vb_d   <= 1'b0;
      r_commit <= 1'b0;
    end else begin
      r_vb_d   <= vblank;
      r_commit <= w_commit;
      for (int n = 0; n < NREGS; n++) begin
        if (w_commit && !IMM_MASK[n]) r_active[n] <= r_shadow[n];
      end
      if (w_a_wr) begin
        r_shadow[addr] <= w_merged;
        if (IMM_MASK[addr]) r_active[addr] <= w_merged;
      end
      if (w_dly_wr)      r_dirty <= 1'b1;
      else if (w_commit) r_dirty <= 1'b0;
    end
  end

  generate
    for (genvar g = 0; g < NREGS; g++) begin : g_flat
      assign regs_act[16*g +: 16] = r_active[g];
    end
  endgenerate

  // DMA / palette requests: armed by writes, fired once the CPU leaves CPS-A
  always_ff @(posedge clk or posedge reg_rst) begin
    if (reg_rst) begin
      r_arm_dma <= 1'b0;
      r_arm_pal <= 1'b0;
      r_dma     <= 1'b0;
      r_pal     <= 1'b0;
    end else begin
      r_dma <= 1'b0;
      r_pal <= 1'b0;
      if (pxl_cen && !ppu1_cs) begin
        if (r_arm_dma) begin
          r_dma     <= 1'b1;
          r_arm_dma <= 1'b0;
        end
        if (r_arm_pal) begin
          r_pal     <= 1'b1;
          r_arm_pal <= 1'b0;
        end
      end
      if (w_a_wr && addr == 5'd0) r_arm_dma <= 1'b1;
      if (w_a_wr && addr == 5'd5) r_arm_pal <= 1'b1;
    end
  end

  // Multiplier operand load / start decode
  logic            w_b_wr, w_m1_ld, w_m2_ld, w_start;
  logic [MULW-1:0] w_m1_nxt, w_m2_nxt;
  logic [2*MULW-1:0] w_acc_nxt;
  assign w_b_wr    = ppu2_cs && (dsn == 2'b00);
  assign w_m1_ld   = w_b_wr && (addr == w_m1_addr) && (w_m1_addr != 5'h1f);
  assign w_m2_ld   = w_b_wr && (addr == w_m2_addr) && (w_m2_addr != 5'h1f);
  assign w_start   = w_m1_ld || w_m2_ld;
  assign w_m1_nxt  = w_m1_ld ? cpu_dout[MULW-1:0] : r_mult1;
  assign w_m2_nxt  = w_m2_ld ? cpu_dout[MULW-1:0] : r_mult2;
  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // Shift-add multiplier; result register only changes on the final step
  always_ff @(posedge clk or posedge reg_rst) begin
    if (reg_rst) begin
      r_mult1  <= '0;
      r_mult2  <= '0;
      r_mplier <= '0;
      r_rslt   <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (w_start) begin
      r_mult1  <= w_m1_nxt;
      r_mult2  <= w_m2_nxt;
      r_acc    <= '0;
      r_mcand  <= {{MULW{1'b0}}, w_m1_nxt};
      r_mplier <= w_m2_nxt;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (r_cnt == c_last) begin
        r_rslt <= w_acc_nxt;
        r_busy <= 1'b0;
      end
    end
  end

  // CPS-B read mux with fixed match priority
  logic [15:0] w_b_rd, w_a_rd;
  always_comb begin
    w_b_rd = 16'hffff;
    if (addr == 5'h1f)          w_b_rd = 16'hffff;
    else if (addr == w_id_addr) w_b_rd = {4'd0, w_id_val[7:4], 4'd0, w_id_val[3:0]};
    else if (addr == w_m1_addr) w_b_rd = 16'(r_mult1);
    else if (addr == w_m2_addr) w_b_rd = 16'(r_mult2);
    else if (addr == w_r0_addr) w_b_rd = 16'(r_rslt[MULW-1:0]);
    else if (addr == w_r1_addr) w_b_rd = 16'(r_rslt[2*MULW-1:MULW]);
  end

`ifdef JTCPS_MMR_READBACK_EN
  assign w_a_rd = w_a_hit ? r_shadow[addr] : 16'hffff;
`else
  assign w_a_rd = 16'hffff;
`endif

  // Registered read data, held between accesses
  always_ff @(posedge clk or posedge reg_rst) begin
    if (reg_rst)      r_dout <= 16'hffff;
    else if (ppu2_cs) r_dout <= w_b_rd;
    else if (ppu1_cs) r_dout <= w_a_rd;
  end

  assign mmr_dout   = r_dout;
  assign commit     = r_commit;
  assign obj_dma_ok = r_dma;
  assign pal_copy   = r_pal;
  assign mul_busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_jtcps_mmr_shadow.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtcps_mmr_shadow
// Purpose  : Self-checking bench for jtcps_mmr_shadow: directed scenarios
//            plus randomized bus traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtcps_mmr_shadow;
  localparam int          NREGS    = 18;
  localparam int          MULW     = 16;
  localparam logic [31:0] IMM_MASK = 32'h0000_0021;

  logic clk = 1'b0;
  logic reg_rst, pxl_cen, vblank, ppu1_cs, ppu2_cs, cfg_we;
  logic [4:0]  addr;
  logic [1:0]  dsn;
  logic [15:0] cpu_dout, mmr_dout;
  logic [7:0]  cfg_data;
  logic [16*NREGS-1:0] regs_act;
  logic commit, obj_dma_ok, pal_copy, mul_busy;

  int n_tests = 0;
  int n_fail  = 0;

  jtcps_mmr_shadow #(.NREGS(NREGS), .MULW(MULW), .IMM_MASK(IMM_MASK), .CFGSIZE(8)) dut (
    .clk(clk), .reg_rst(reg_rst), .pxl_cen(pxl_cen), .vblank(vblank),
    .ppu1_cs(ppu1_cs), .ppu2_cs(ppu2_cs), .addr(addr), .dsn(dsn),
    .cpu_dout(cpu_dout), .mmr_dout(mmr_dout), .cfg_we(cfg_we), .cfg_data(cfg_data),
    .regs_act(regs_act), .commit(commit), .obj_dma_ok(obj_dma_ok),
    .pal_copy(pal_copy), .mul_busy(mul_busy)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [15:0] m_sh [32];
  logic [15:0] m_ac [32];
  logic [7:0]  m_cfg [8];
  logic [15:0] m_m1, m_m2, m_dout;
  logic [31:0] m_rs, m_pend;
  bit          m_dirty, m_vb, m_arm_d, m_arm_p;
  bit          e_commit, e_dma, e_pal;
  int          m_left;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] act(input int n);
    return regs_act[16*n +: 16];
  endfunction

  function automatic logic [4:0] caddr(input int k);
    logic [7:0] b;
    b = m_cfg[k];
    return b[5:1];
  endfunction

  function automatic logic [15:0] b_read(input logic [4:0] a);
    logic [7:0] idv;
    idv = m_cfg[1];
    if (a == 5'h1f)     return 16'hffff;
    if (a == caddr(0))  return {4'd0, idv[7:4], 4'd0, idv[3:0]};
    if (a == caddr(2))  return m_m1;
    if (a == caddr(3))  return m_m2;
    if (a == caddr(4))  return m_rs[15:0];
    if (a == caddr(5))  return m_rs[31:16];
    return 16'hffff;
  endfunction

  function automatic logic [15:0] a_read(input logic [4:0] a);
`ifdef JTCPS_MMR_READBACK_EN
    if (int'(a) < NREGS) return m_sh[a];
`endif
    return (a == a) ? 16'hffff : 16'h0000;
  endfunction

  // One clock: advance the model from the spec rules, then compare strobes
  task automatic tick();
    logic [15:0] mg;
    bit rise;
    if (ppu2_cs)      m_dout = b_read(addr);
    else if (ppu1_cs) m_dout = a_read(addr);
    rise = vblank && !m_vb;
    m_vb = vblank;
    e_commit = rise && m_dirty;
    if (e_commit) begin
      for (int k = 0; k < NREGS; k++) if (!IMM_MASK[k]) m_ac[k] = m_sh[k];
      m_dirty = 0;
    end
    e_dma = 0;
    e_pal = 0;
    if (pxl_cen && !ppu1_cs) begin
      e_dma = m_arm_d; e_pal = m_arm_p;
      m_arm_d = 0;     m_arm_p = 0;
    end
    if (ppu1_cs && int'(addr) < NREGS && dsn != 2'b11) begin
      mg = m_sh[addr];
      if (!dsn[1]) mg[15:8] = cpu_dout[15:8];
      if (!dsn[0]) mg[7:0]  = cpu_dout[7:0];
      m_sh[addr] = mg;
      if (IMM_MASK[addr]) m_ac[addr] = mg;
      else m_dirty = 1;
      if (addr == 5'd0) m_arm_d = 1;
      if (addr == 5'd5) m_arm_p = 1;
    end
    if (ppu2_cs && dsn == 2'b00 && addr != 5'h1f && (addr == caddr(2) || addr == caddr(3))) begin
      if (addr == caddr(2)) m_m1 = cpu_dout;
      if (addr == caddr(3)) m_m2 = cpu_dout;
      m_pend = 32'(m_m1) * 32'(m_m2);
      m_left = MULW;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_rs = m_pend;
    end
    if (cfg_we) begin
      for (int k = 0; k < 7; k++) m_cfg[k] = m_cfg[k+1];
      m_cfg[7] = cfg_data;
    end
    @(posedge clk);
    #1;
    check("commit", commit, e_commit);
    check("obj_dma_ok", obj_dma_ok, e_dma);
    check("pal_copy", pal_copy, e_pal);
    check("mul_busy", mul_busy, m_left > 0);
    check("mmr_dout", mmr_dout, m_dout);
  endtask

  task automatic idle(input int n);
    ppu1_cs = 0; ppu2_cs = 0; dsn = 2'b11; cfg_we = 0;
    repeat (n) tick();
  endtask

  task automatic wr1(input logic [4:0] a, input logic [15:0] d, input logic [1:0] ds);
    ppu1_cs = 1; addr = a; dsn = ds; cpu_dout = d;
    tick();
    ppu1_cs = 0; dsn = 2'b11;
  endtask

  task automatic acc2(input logic [4:0] a, input logic [15:0] d, input logic [1:0] ds);
    ppu2_cs = 1; addr = a; dsn = ds; cpu_dout = d;
    tick();
    ppu2_cs = 0; dsn = 2'b11;
  endtask

  task automatic vb_edge();
    vblank = 1; tick();
    vblank = 0; tick();
  endtask

  initial begin
    logic [7:0]  cfgb [8];
    logic [4:0]  pick [6];
    int cnt;
    reg_rst = 1; pxl_cen = 1; vblank = 0; ppu1_cs = 0; ppu2_cs = 0;
    addr = '0; dsn = 2'b11; cpu_dout = '0; cfg_we = 0; cfg_data = '0;
    for (int k = 0; k < 32; k++) begin m_sh[k] = '0; m_ac[k] = '0; end
    for (int k = 0; k < 8; k++) m_cfg[k] = '0;
    m_m1 = '0; m_m2 = '0; m_rs = '0; m_pend = '0; m_left = 0; m_dout = 16'hffff;
    m_dirty = 0; m_vb = 0; m_arm_d = 0; m_arm_p = 0;
    repeat (3) @(posedge clk);
    #1;
    reg_rst = 0;

    // Reset state
    for (int k = 0; k < NREGS; k++) check("rst_act", act(k), 16'h0000);
    check("rst_dout", mmr_dout, 16'hffff);
    check("rst_commit", commit, 1'b0);
    check("rst_busy", mul_busy, 1'b0);
    check("rst_dma", obj_dma_ok, 1'b0);
    check("rst_pal", pal_copy, 1'b0);

    // Config download: id @0x10 = 0x14, mult1..rslt1 @ 0x01..0x04
    cfgb = '{8'h20, 8'h14, 8'h02, 8'h04, 8'h06, 8'h08, 8'h00, 8'h00};
    for (int k = 0; k < 8; k++) begin
      cfg_we = 1; cfg_data = cfgb[k];
      tick();
    end
    cfg_we = 0;

    // Shadowed register commits only on the vblank edge
    wr1(5'd6, 16'h1234, 2'b00);
    idle(3);
    check("pre_vb_act6", act(6), 16'h0000);
    vblank = 1; tick();
    check("vb_act6", act(6), 16'h1234);
    check("vb_pulse", commit, 1'b1);
    tick();
    check("vb_pulse_end", commit, 1'b0);
    vblank = 0; idle(2);

    // Write coinciding with the commit edge
    wr1(5'd6, 16'h00aa, 2'b00);
    ppu1_cs = 1; addr = 5'd6; dsn = 2'b00; cpu_dout = 16'h1234; vblank = 1;
    tick();
    ppu1_cs = 0; dsn = 2'b11;
    check("same_cyc_act6", act(6), 16'h00aa);
    check("same_cyc_pulse", commit, 1'b1);
    vblank = 0; idle(2);
    vblank = 1; tick();
    check("second_act6", act(6), 16'h1234);
    check("second_pulse", commit, 1'b1);
    vblank = 0; idle(1);

    // Byte lanes
    wr1(5'd7, 16'habcd, 2'b10);
    vb_edge();
    check("byte_lo_act7", act(7), 16'h00cd);
    wr1(5'd7, 16'h5600, 2'b01);
    vb_edge();
    check("byte_hi_act7", act(7), 16'h56cd);

    // No commit pulse when nothing is dirty
    vblank = 1; tick();
    check("clean_no_pulse", commit, 1'b0);
    vblank = 0; idle(1);

    // Multiplier
    acc2(5'h01, 16'h1234, 2'b00);
    acc2(5'h02, 16'h5678, 2'b00);
    cnt = 0;
    while (mul_busy && cnt < 100) begin cnt++; tick(); end
    check("mul_busy_len", cnt, MULW);
    acc2(5'h03, 16'h0000, 2'b11);
    check("rslt0", mmr_dout, 16'h0060);
    acc2(5'h04, 16'h0000, 2'b11);
    check("rslt1", mmr_dout, 16'h0626);
    acc2(5'h01, 16'h0003, 2'b00);
    idle(4);
    acc2(5'h03, 16'h0000, 2'b11);
    check("busy_old_rslt0", mmr_dout, 16'h0060);
    idle(20);
    acc2(5'h03, 16'h0000, 2'b11);
    check("rslt0_3x", mmr_dout, 16'h0368);

    // DMA / palette strobes
    ppu1_cs = 1; dsn = 2'b00; addr = 5'd0; cpu_dout = 16'h1111; tick();
    addr = 5'd5; cpu_dout = 16'h2222; tick();
    dsn = 2'b11; tick();
    check("dma_held", obj_dma_ok, 1'b0);
    ppu1_cs = 0; pxl_cen = 0; tick(); tick();
    check("dma_no_cen", obj_dma_ok, 1'b0);
    pxl_cen = 1; tick();
    check("dma_pulse", obj_dma_ok, 1'b1);
    check("pal_pulse", pal_copy, 1'b1);
    check("imm_act0", act(0), 16'h1111);
    check("imm_act5", act(5), 16'h2222);
    check("imm_no_commit", commit, 1'b0);
    tick();
    check("dma_single", obj_dma_ok, 1'b0);

    // ID and unmapped reads
    acc2(5'h10, 16'h0000, 2'b11);
    check("id_read", mmr_dout, 16'h0104);
    acc2(5'h1f, 16'h0000, 2'b11);
    check("addr1f_read", mmr_dout, 16'hffff);
    wr1(5'd6, 16'h0000, 2'b11);
`ifdef JTCPS_MMR_READBACK_EN
    check("cpsa_read", mmr_dout, 16'h1234);
`else
    check("cpsa_read", mmr_dout, 16'hffff);
`endif

    // Randomized bus traffic
    pick = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h10, 5'h1f};
    for (int i = 0; i < 600; i++) begin
      int r, k;
      r = int'($urandom_range(0, 9));
      ppu1_cs = 0; ppu2_cs = 0; dsn = 2'b11;
      cpu_dout = 16'($urandom);
      if (r < 5) begin
        ppu1_cs = 1; addr = 5'($urandom_range(0, 31)); dsn = 2'($urandom);
      end else if (r < 8) begin
        ppu2_cs = 1;
        addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : pick[$urandom_range(0, 5)];
        dsn = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
      end
      if ($urandom_range(0, 7) == 0) vblank = ~vblank;
      pxl_cen = 1'($urandom);
      tick();
      k = int'($urandom_range(0, NREGS-1));
      check("rand_act", act(k), m_ac[k]);
    end
    idle(MULW + 2);
    for (int k = 0; k < NREGS; k++) check("final_act", act(k), m_ac[k]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
